// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared definitions for the UART receiver.
//   - 2-bit FSM state encoding (IDLE, START, DATA, STOP)
//   - clog2 helper for sizing the tick and bit counters
package uart_rx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } state_e;

  // Bits needed to hold values 0..v-1 (minimum 1).
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so the line reads idle out of reset.
//   i_clk   : system clock
//   i_reset : asynchronous, active-high reset
//   i_d     : asynchronous input
//   o_q     : synchronized output (second flop)
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], i_d};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) sync_q <= 2'b11;
    else         sync_q <= sync_d;
  end

  assign o_q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver driven by an oversampling tick.
// Frame: 1 start bit, DATA_BITS data bits (LSB first), stop spanning SB_TICKS ticks.
//   i_clk       : system clock
//   i_reset     : asynchronous, active-high reset
//   i_tick      : one-cycle oversampling strobe, OVERSAMPLE per bit
//   i_rx        : serial line, idle high, asynchronous to i_clk
//   o_data      : last received word, held until the next o_rx_done
//   o_rx_done   : one-cycle pulse when a frame completes
//   o_frame_err : 1 if the last frame's stop sample was 0
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int SB_TICKS   = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err
);

  localparam int SW = clog2((OVERSAMPLE > SB_TICKS) ? OVERSAMPLE : SB_TICKS);
  localparam int NW = clog2(DATA_BITS);

  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  state_e                 state_q, state_d;
  logic [SW-1:0]          s_cnt_q, s_cnt_d;
  logic [NW-1:0]          n_cnt_q, n_cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   data_q,  data_d;
  logic                   done_q,  done_d;
  logic                   ferr_q,  ferr_d;

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    case (state_q)
      // Start detection runs every clock so a start edge is never missed
      // waiting for a tick.
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end
      START: begin
        if (i_tick) begin
          if (s_cnt_q == S_MID) begin
            // Centre of start bit: a high line here was only a glitch.
            if (!rx_s) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (s_cnt_q == S_BIT) begin
            s_cnt_d = '0;
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            if (n_cnt_q == N_LAST) state_d = STOP;
            else                   n_cnt_d = n_cnt_q + NW'(1);
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (i_tick) begin
          if (s_cnt_q == S_STOP) begin
            data_d  = shreg_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_data      = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int OS = 16;
  localparam int DB = 8;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b1;
  logic i_tick  = 1'b0;
  logic i_rx    = 1'b1;

  logic [DB-1:0] o_data_w [2];
  logic          o_done_w [2];
  logic          o_ferr_w [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int tick_div = 16;
  int tcnt     = 0;

  always #5 i_clk = ~i_clk;

  // Instance 0: one stop bit; instance 1: two stop bits. Both see the same line.
  uart_rx #(.DATA_BITS(DB), .SB_TICKS(16), .OVERSAMPLE(OS)) dut0 (
    .i_clk(i_clk), .i_reset(i_reset), .i_tick(i_tick), .i_rx(i_rx),
    .o_data(o_data_w[0]), .o_rx_done(o_done_w[0]), .o_frame_err(o_ferr_w[0]));

  uart_rx #(.DATA_BITS(DB), .SB_TICKS(32), .OVERSAMPLE(OS)) dut1 (
    .i_clk(i_clk), .i_reset(i_reset), .i_tick(i_tick), .i_rx(i_rx),
    .o_data(o_data_w[1]), .o_rx_done(o_done_w[1]), .o_frame_err(o_ferr_w[1]));

  always @(posedge i_clk) cyc <= cyc + 1;

  // Tick strobe every tick_div clocks.
  initial forever begin
    @(negedge i_clk);
    if (tcnt >= tick_div - 1) begin tcnt = 0; i_tick = 1'b1; end
    else begin tcnt++; i_tick = 1'b0; end
  end

  function automatic int sb_of(input int g);
    return (g == 0) ? 16 : 32;
  endfunction

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h exp=%0h cyc=%0d", name, g, act, exp, cyc);
    end
  endtask

  // Reference model: the line is seen two clocks late; a frame starts on the
  // first clock that sees it low while idle. Counting ticks strictly after
  // that clock, the start is checked at OS/2, data bit k at OS/2+OS*(k+1),
  // and the stop at OS/2+OS*DB+SB where the word is delivered.
  bit            m_s1 [2];
  bit            m_s2 [2];
  bit            busy [2];
  int            t0   [2];
  int            tcount;
  logic [DB-1:0] word     [2];
  logic          exp_done [2];
  logic [DB-1:0] exp_data [2];
  logic          exp_ferr [2];

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tcount = 0;
      for (int g = 0; g < 2; g++) begin
        m_s1[g] = 1'b1; m_s2[g] = 1'b1; busy[g] = 1'b0; t0[g] = 0;
        word[g] = '0; exp_done[g] = 1'b0; exp_data[g] = '0; exp_ferr[g] = 1'b0;
      end
    end else begin
      if (i_tick) tcount++;
      for (int g = 0; g < 2; g++) begin
        bit rxs;
        int rel;
        rxs = m_s2[g]; m_s2[g] = m_s1[g]; m_s1[g] = i_rx;
        exp_done[g] = 1'b0;
        if (!busy[g]) begin
          if (!rxs) begin busy[g] = 1'b1; t0[g] = tcount; end
        end else if (i_tick) begin
          rel = tcount - t0[g];
          if (rel == OS/2) begin
            if (rxs) busy[g] = 1'b0;
          end else if (rel > OS/2 && (rel - OS/2) % OS == 0 && (rel - OS/2) / OS <= DB) begin
            word[g][(rel - OS/2) / OS - 1] = rxs;
          end
          if (rel == OS/2 + OS*DB + sb_of(g)) begin
            exp_done[g] = 1'b1; exp_data[g] = word[g]; exp_ferr[g] = ~rxs; busy[g] = 1'b0;
          end
        end
      end
    end
  end

  int done_cnt  [2] = '{0, 0};
  int last_done [2] = '{0, 0};
  int prev_done [2] = '{0, 0};

  // Per-cycle comparison against the model.
  always @(negedge i_clk) begin
    for (int g = 0; g < 2; g++) begin
      chk("done", g, 32'(o_done_w[g]), 32'(exp_done[g]));
      chk("data", g, 32'(o_data_w[g]), 32'(exp_data[g]));
      chk("ferr", g, 32'(o_ferr_w[g]), 32'(exp_ferr[g]));
      if (o_done_w[g] === 1'b1) begin
        done_cnt[g]++; prev_done[g] = last_done[g]; last_done[g] = cyc;
      end
    end
  end

  task automatic tick_wait();
    do @(posedge i_clk); while (!i_tick);
    @(negedge i_clk);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) tick_wait();
  endtask

  // Call right after tick_wait(); returns at the end of the stop period.
  task automatic send_frame(input logic [7:0] d, input logic stopv, input int sp, output int c0);
    c0 = cyc;
    i_rx = 1'b0; wait_ticks(OS);
    for (int k = 0; k < DB; k++) begin i_rx = d[k]; wait_ticks(OS); end
    i_rx = stopv; wait_ticks(OS * sp);
  endtask

  initial begin
    int c, c2, n0, n1;
    #3_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c, n0, n1;
    repeat (3) @(posedge i_clk);
    #2 i_reset = 1'b0;
    #1;
    chk("rst_data", 0, 32'(o_data_w[0]), 32'h0);
    chk("rst_done", 0, 32'(o_done_w[0]), 32'h0);
    chk("rst_ferr", 0, 32'(o_ferr_w[0]), 32'h0);
    wait_ticks(4);

    // 1: 0xA5, stop=1.
    tick_wait();
    n0 = done_cnt[0];
    send_frame(8'hA5, 1'b1, 1, c);
    chk("t1_cnt",  0, 32'(done_cnt[0] - n0), 32'd1);
    chk("t1_data", 0, 32'(o_data_w[0]), 32'hA5);
    chk("t1_ferr", 0, 32'(o_ferr_w[0]), 32'h0);
    chk("t1_lat",  0, 32'(last_done[0] - c), 32'd2432);
    i_rx = 1'b1; wait_ticks(20);

    // 2: 0x00 then 0xFF back to back.
    n0 = done_cnt[0];
    send_frame(8'h00, 1'b1, 1, c);
    chk("t2_d0", 0, 32'(o_data_w[0]), 32'h00);
    send_frame(8'hFF, 1'b1, 1, c);
    chk("t2_cnt",  0, 32'(done_cnt[0] - n0), 32'd2);
    chk("t2_d1",   0, 32'(o_data_w[0]), 32'hFF);
    chk("t2_ferr", 0, 32'(o_ferr_w[0]), 32'h0);
    chk("t2_gap",  0, 32'(last_done[0] - prev_done[0]), 32'd2560);
    i_rx = 1'b1;

    // 3: short low pulse is a false start.
    tick_div = 4; wait_ticks(200);
    n0 = done_cnt[0];
    i_rx = 1'b0; wait_ticks(3); i_rx = 1'b1; wait_ticks(40);
    chk("t3_cnt",  0, 32'(done_cnt[0] - n0), 32'd0);
    chk("t3_data", 0, 32'(o_data_w[0]), 32'hFF);

    // 4: framing error, then a clean frame.
    n0 = done_cnt[0];
    send_frame(8'h3C, 1'b0, 1, c);
    chk("t4_cnt",  0, 32'(done_cnt[0] - n0), 32'd1);
    chk("t4_data", 0, 32'(o_data_w[0]), 32'h3C);
    chk("t4_ferr", 0, 32'(o_ferr_w[0]), 32'h1);
    i_rx = 1'b1; wait_ticks(200);
    send_frame(8'h5A, 1'b1, 1, c);
    chk("t4b_data", 0, 32'(o_data_w[0]), 32'h5A);
    chk("t4b_ferr", 0, 32'(o_ferr_w[0]), 32'h0);
    i_rx = 1'b1; wait_ticks(20);

    // Break: stuck-low line yields repeated zero words with framing error.
    n0 = done_cnt[0];
    i_rx = 1'b0; wait_ticks(400);
    chk("brk_cnt",  0, 32'(done_cnt[0] - n0 >= 2), 32'd1);
    chk("brk_data", 0, 32'(o_data_w[0]), 32'h0);
    chk("brk_ferr", 0, 32'(o_ferr_w[0]), 32'h1);
    i_rx = 1'b1; wait_ticks(200);

    // 5: reset during data bit 4 of 0x96, then 0x81.
    n0 = done_cnt[0];
    i_rx = 1'b0; wait_ticks(OS);
    for (int k = 0; k < 4; k++) begin i_rx = (k == 1 || k == 2); wait_ticks(OS); end
    i_rx = 1'b1; wait_ticks(OS/2);
    @(posedge i_clk); #2 i_reset = 1'b1; #1;
    chk("t5_data", 0, 32'(o_data_w[0]), 32'h0);
    chk("t5_done", 0, 32'(o_done_w[0]), 32'h0);
    @(posedge i_clk); #2 i_reset = 1'b0;
    wait_ticks(200);
    chk("t5_cnt", 0, 32'(done_cnt[0] - n0), 32'd0);
    send_frame(8'h81, 1'b1, 1, c);
    chk("t5b_data", 0, 32'(o_data_w[0]), 32'h81);
    chk("t5b_ferr", 0, 32'(o_ferr_w[0]), 32'h0);
    i_rx = 1'b1;

    // 6: two stop bits on the SB_TICKS=32 instance.
    tick_div = 16; wait_ticks(200);
    n1 = done_cnt[1];
    send_frame(8'h7E, 1'b1, 2, c);
    chk("t6_cnt",  1, 32'(done_cnt[1] - n1), 32'd1);
    chk("t6_data", 1, 32'(o_data_w[1]), 32'h7E);
    chk("t6_ferr", 1, 32'(o_ferr_w[1]), 32'h0);
    chk("t6_lat",  1, 32'(last_done[1] - c), 32'd2688);
    i_rx = 1'b1; wait_ticks(10);

    // Randomized frames, glitches, framing errors and tick rates.
    for (int it = 0; it < 40; it++) begin
      int kind;
      logic [7:0] d;
      tick_div = $urandom_range(1, 4);
      tick_wait();
      d = 8'($urandom);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        i_rx = 1'b0; wait_ticks($urandom_range(1, 7));
      end else begin
        send_frame(d, (kind == 1) ? 1'b0 : 1'b1, (kind == 2) ? 2 : 1, c);
      end
      i_rx = 1'b1; wait_ticks($urandom_range(0, 24));
    end
    i_rx = 1'b1; wait_ticks(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
